arcade_input_mapper: RTL
========================

Name: arcade_input_mapper

Overview:
- Parametrised input front-end for arcade cores: decodes PS/2 key events and merges them with per-player joystick words into registered per-player button vectors.
- Adds coin pulse stretching and opposite-direction (SOCD) cleaning, which the per-core ad-hoc keyboard decoders lack.
- Sits between hps_io and the game core; one instance replaces each core's inline keyboard block.

Parameters:
- NUM_PLAYERS, 2, number of player button vectors (1..4); keyboard maps players 0 and 1 only.
- COIN_PULSE, 24'd480000, coin output high time in clk_sys cycles (10 ms at 48 MHz); must be ≥ 1.
- SOCD_MODE, 0, 0 = pass opposite directions through; 1 = left+right → neither, up+down → neither.
- AUTOFIRE_DIV, 20'd400000, half-period of autofire square wave in cycles (used only with AUTOFIRE_EN).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
- joy_in  in  NUM_PLAYERS*16  per-player joystick words; player p at [p*16 +: 16].
- btn_out  out  NUM_PLAYERS*8  per-player buttons; player p at [p*8 +: 8].
- key_event  out  1  one-cycle pulse per accepted mapped key event.
- autofire_sel  in  NUM_PLAYERS  per-player autofire request (present only with AUTOFIRE_EN).

Behaviour:
- Button bit order, shared by joy_in[7:0] and btn_out: 0 right, 1 left, 2 down, 3 up, 4 fire1, 5 fire2, 6 start, 7 coin. joy_in[15:8] is ignored.
- Event detect: toggle_q <= ps2_key[10]. An event is a cycle where ps2_key[10] != toggle_q. toggle_q resets to 0.
- Key state: one register per mapped key, not per button. On an event, the matching key register <= ps2_key[9]. Unmapped codes have no effect and do not assert key_event.
- Player 0 keys:
  - Arrows 75/72/6B/74 map to up/down/left/right. The extended bit is ignored.
  - Ctrl 014 and space 029 map to fire1.
  - Alt 011 maps to fire2.
  - 016 ("1") and F1 005 map to start.
  - 02E ("5") maps to coin.
- Player 1 keys:
  - W 01D up, A 01C left, S 01B down, D 023 right.
  - Q 015 fire1, E 024 fire2.
  - 01E ("2") and F2 006 map to start.
  - 036 ("6") maps to coin.
- A keyboard button is the OR of its keys. Releasing space while ctrl is held keeps fire1 = 1.
- Merge: raw[p] = kbd[p] | joy_in[p][7:0]. Players ≥ 2 use joystick only.
- SOCD (SOCD_MODE = 1) is applied combinationally on raw before the output register.
- Output register: btn_out <= cleaned raw. Latency is 2 cycles from the ps2_key toggle edge and 1 cycle from a joy_in change.
- key_event is registered and asserts on the cycle the key register updates.
- Coin stretcher, per player:
  - Fires on the rising edge of raw coin, i.e. raw coin = 1 while the previous-cycle raw coin = 0.
  - On that edge, load counter = COIN_PULSE; btn_out coin bit = (counter != 0); counter decrements each cycle.
  - Coin output is exactly COIN_PULSE cycles regardless of input hold length.
  - Edges while counter != 0 are ignored (no retrigger).
  - A coin held past pulse end does not re-fire; release and re-press are required.
- Reset mid-operation clears the following on the next edge:
  - all key registers;
  - toggle_q;
  - coin counters and edge registers;
  - btn_out = 0 and key_event = 0.
- Widths: counters are 24 bits. COIN_PULSE larger than 2^24−1 is illegal.

Optional Feature:
- Macro: ARCADE_INPUT_AUTOFIRE_EN.
- Defined:
  - A free-running 20-bit divider toggles af_phase every AUTOFIRE_DIV cycles.
  - For player p with autofire_sel[p] = 1, fire1 out = raw fire1 & af_phase.
  - The divider and af_phase reset to 0.
- Undefined: the autofire_sel port, divider and AUTOFIRE_DIV logic are absent; fire1 passes straight through.

Test Plan:
- Reset, then ps2_key = {1,1,0,8'h29} → btn_out[4] = 1 exactly 2 cycles after the toggle; key_event pulses once; all other bits 0.
- Press 014, press 029, release 029 → btn_out[4] stays 1; release 014 → btn_out[4] = 0 two cycles later.
- COIN_PULSE = 16, joy_in[7] held 100 cycles → btn_out[7] high exactly 16 cycles. Second press at cycle 5 of the pulse → no extension. Release, then press at cycle 40 → new 16-cycle pulse.
- SOCD_MODE = 1, joy_in[1:0] = 2'b11 → btn_out[1:0] = 00. SOCD_MODE = 0, same input → 11.
- NUM_PLAYERS = 3, keyboard W event plus joy_in[32+3] = 1 → btn_out[11] = 1 (player 1 up) and btn_out[19] = 1 (player 2 up).
- Unmapped scancode 8'h0A toggled → no key_event, btn_out unchanged. With ARCADE_INPUT_AUTOFIRE_EN, AUTOFIRE_DIV = 4, fire1 held → fire1 out toggles every 4 cycles.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// PS/2 key decoder merged with per-player joystick words into registered button vectors,
// with coin pulse stretching and optional SOCD cleaning. Autofire: ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter logic [23:0] COIN_PULSE  = 24'd480000,
    parameter int unsigned SOCD_MODE   = 0
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    ,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
`endif
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [10:0]              ps2_key,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  logic [NUM_PLAYERS-1:0]   autofire_sel,
`endif
    input  logic [NUM_PLAYERS*16-1:0] joy_in,
    output logic [NUM_PLAYERS*8-1:0] btn_out,
    output logic                     key_event
);

    localparam int unsigned NUM_KEYS = 19;

    localparam int unsigned K0_UP    = 0;
    localparam int unsigned K0_DOWN  = 1;
    localparam int unsigned K0_LEFT  = 2;
    localparam int unsigned K0_RIGHT = 3;
    localparam int unsigned K0_CTRL  = 4;
    localparam int unsigned K0_SPACE = 5;
    localparam int unsigned K0_ALT   = 6;
    localparam int unsigned K0_ONE   = 7;
    localparam int unsigned K0_F1    = 8;
    localparam int unsigned K0_FIVE  = 9;
    localparam int unsigned K1_UP    = 10;
    localparam int unsigned K1_LEFT  = 11;
    localparam int unsigned K1_DOWN  = 12;
    localparam int unsigned K1_RIGHT = 13;
    localparam int unsigned K1_FIRE1 = 14;
    localparam int unsigned K1_FIRE2 = 15;
    localparam int unsigned K1_TWO   = 16;
    localparam int unsigned K1_F2    = 17;
    localparam int unsigned K1_SIX   = 18;

    logic                toggle_q;
    logic [NUM_KEYS-1:0] keys_q;
    logic [NUM_KEYS-1:0] key_hit_c;
    logic                event_c;
    logic [7:0]          kbd_c [2];
    logic                unused_c;

    assign event_c  = ps2_key[10] ^ toggle_q;
    assign unused_c = ^{ps2_key[8], joy_in};

    // Scancode to key-register decode; the extended bit is deliberately ignored.
    always_comb begin
        key_hit_c = '0;
        case (ps2_key[7:0])
            8'h75: key_hit_c[K0_UP]    = 1'b1;
            8'h72: key_hit_c[K0_DOWN]  = 1'b1;
            8'h6B: key_hit_c[K0_LEFT]  = 1'b1;
            8'h74: key_hit_c[K0_RIGHT] = 1'b1;
            8'h14: key_hit_c[K0_CTRL]  = 1'b1;
            8'h29: key_hit_c[K0_SPACE] = 1'b1;
            8'h11: key_hit_c[K0_ALT]   = 1'b1;
            8'h16: key_hit_c[K0_ONE]   = 1'b1;
            8'h05: key_hit_c[K0_F1]    = 1'b1;
            8'h2E: key_hit_c[K0_FIVE]  = 1'b1;
            8'h1D: key_hit_c[K1_UP]    = 1'b1;
            8'h1C: key_hit_c[K1_LEFT]  = 1'b1;
            8'h1B: key_hit_c[K1_DOWN]  = 1'b1;
            8'h23: key_hit_c[K1_RIGHT] = 1'b1;
            8'h15: key_hit_c[K1_FIRE1] = 1'b1;
            8'h24: key_hit_c[K1_FIRE2] = 1'b1;
            8'h1E: key_hit_c[K1_TWO]   = 1'b1;
            8'h06: key_hit_c[K1_F2]    = 1'b1;
            8'h36: key_hit_c[K1_SIX]   = 1'b1;
            default: key_hit_c = '0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle_q  <= 1'b0;
            keys_q    <= '0;
            key_event <= 1'b0;
        end else begin
            toggle_q  <= ps2_key[10];
            key_event <= event_c & (|key_hit_c);
            if (event_c) begin
                keys_q <= (keys_q & ~key_hit_c) | (key_hit_c & {NUM_KEYS{ps2_key[9]}});
            end
        end
    end

    // Buttons are the OR of their keys: {coin, start, fire2, fire1, up, down, left, right}.
    assign kbd_c[0] = {keys_q[K0_FIVE], keys_q[K0_ONE] | keys_q[K0_F1], keys_q[K0_ALT],
                       keys_q[K0_CTRL] | keys_q[K0_SPACE], keys_q[K0_UP], keys_q[K0_DOWN],
                       keys_q[K0_LEFT], keys_q[K0_RIGHT]};
    assign kbd_c[1] = {keys_q[K1_SIX], keys_q[K1_TWO] | keys_q[K1_F2], keys_q[K1_FIRE2],
                       keys_q[K1_FIRE1], keys_q[K1_UP], keys_q[K1_DOWN],
                       keys_q[K1_LEFT], keys_q[K1_RIGHT]};

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [19:0] af_cnt_q;
    logic        af_phase;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt_q <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt_q >= AUTOFIRE_DIV - 20'd1) begin
            af_cnt_q <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt_q <= af_cnt_q + 20'd1;
        end
    end
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [7:0]  raw_c;
        logic [7:0]  clean_c;
        logic [7:0]  btn_q;
        logic [23:0] coin_cnt_q;
        logic        coin_prev_q;
        logic        coin_fire_c;
        logic        coin_c;

        if (p < 2) begin : g_kbd
            assign raw_c = kbd_c[p] | joy_in[p*16 +: 8];
        end else begin : g_joy
            assign raw_c = joy_in[p*16 +: 8];
        end

        always_comb begin
            clean_c = raw_c;
            if (SOCD_MODE == 1) begin
                if (raw_c[0] & raw_c[1]) clean_c[1:0] = 2'b00;
                if (raw_c[2] & raw_c[3]) clean_c[3:2] = 2'b00;
            end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            if (autofire_sel[p]) clean_c[4] = raw_c[4] & af_phase;
`endif
        end

        // Busy covers the final pulse cycle too, so a re-press there cannot extend it.
        assign coin_fire_c = raw_c[7] & ~coin_prev_q & (coin_cnt_q == 24'd0) & ~btn_q[7];
        assign coin_c      = coin_fire_c | (coin_cnt_q != 24'd0);

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                coin_cnt_q  <= '0;
                coin_prev_q <= 1'b0;
                btn_q       <= '0;
            end else begin
                coin_prev_q <= raw_c[7];
                btn_q       <= {coin_c, clean_c[6:0]};
                if (coin_fire_c) begin
                    coin_cnt_q <= COIN_PULSE - 24'd1;
                end else if (coin_cnt_q != 24'd0) begin
                    coin_cnt_q <= coin_cnt_q - 24'd1;
                end
            end
        end

        assign btn_out[p*8 +: 8] = btn_q;
    end

endmodule
